seq_divider: RTL and testbench

Sequential unsigned non-restoring divider: divides an N-bit dividend by an N-bit divisor, producing one quotient bit per clock. It reuses the team's add/subtract datapath style, where a single Op bit selects addition or subtraction. This block performs the inverse of the multiply/accumulate path. It sits beside the generic adder-subtractor in the arithmetic unit and is driven by a start/done handshake.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_addsub.sv | 16 +
 rtl/seq_divider.sv | 132 +++++++++++++
 tb/tb_seq_divider.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
// - IDLE/ITER/FIX/DONE: state encodings, also wrapped in the state_e enum.
// - cnt_width(n): width of the iteration counter, which must hold the value n.
package div_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StIter = ITER,
    StFix  = FIX,
    StDone = DONE
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_addsub.sv
// Combinational W-bit adder/subtractor.
// - a, b : operands
// - op   : 0 = a + b, 1 = a - b (b inverted, carry-in set)
// - s    : W-bit result, carry-out discarded
module div_addsub #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic [W-1:0] s
);

  assign s = a + (b ^ {W{op}}) + W'(op);

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned non-restoring divider, one quotient bit per clock.
// - clk, rst          : clock, synchronous active-high reset
// - start             : request, accepted in IDLE or DONE
// - dividend, divisor : N-bit operands captured on accept
// - busy              : high in ITER and FIX
// - done              : one-cycle result-valid pulse
// - quotient, remainder, div_by_zero : results, held until the next accept
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = cnt_width(N);

  state_e        state_q, state_d;
  logic [N:0]    p_q, p_d;
  logic [N:0]    d_q, d_d;
  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [N:0] add_a, add_s;
  logic       add_op;
  logic [N:0] p_shift;

  // {P,Q} shifted left by one; only the P half feeds the adder.
  assign p_shift = {p_q[N-1:0], q_q[N-1]};

  // Single adder shared by the ITER step and the FIX correction.
  div_addsub #(
    .W (N + 1)
  ) u_addsub (
    .a  (add_a),
    .b  (d_q),
    .op (add_op),
    .s  (add_s)
  );

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    d_d     = d_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    add_a   = p_shift;
    add_op  = ~p_q[N];

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            p_d     = '0;
            q_d     = dividend;
            d_d     = {1'b0, divisor};
            cnt_d   = CW'(N);
            dbz_d   = 1'b0;
            state_d = StIter;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StIter: begin
        p_d   = add_s;
        q_d   = {q_q[N-2:0], ~add_s[N]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = StFix;
      end
      StFix: begin
        // Negative partial remainder needs one restoring add of D.
        add_a   = p_q;
        add_op  = 1'b0;
        p_d     = p_q[N] ? add_s : p_q;
        quot_d  = q_q;
        rem_d   = p_d[N-1:0];
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      p_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      d_q     <= d_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == StIter) || (state_q == StFix);
  assign done        = (state_q == StDone);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: an N=4 instance for directed vectors and
// an N=8 instance for a sweep against a division reference model.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Edge counter used to time done relative to the accept edge.
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         acc;    // edge number of the accept edge
    int         edges;  // edges from accept edge to the edge raising done
    int         busy;   // expected busy cycles
  } exp_t;

  exp_t sb4[$];
  exp_t sb8[$];

  // N=4 instance
  logic       start4 = 1'b0;
  logic [3:0] dividend4 = '0, divisor4 = '0;
  logic       busy4, done4, dbz4;
  logic [3:0] quot4, rem4;

  seq_divider #(.N(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .start       (start4),
    .dividend    (dividend4),
    .divisor     (divisor4),
    .busy        (busy4),
    .done        (done4),
    .quotient    (quot4),
    .remainder   (rem4),
    .div_by_zero (dbz4)
  );

  // N=8 instance
  logic       start8 = 1'b0;
  logic [7:0] dividend8 = '0, divisor8 = '0;
  logic       busy8, done8, dbz8;
  logic [7:0] quot8, rem8;

  seq_divider #(.N(8)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .start       (start8),
    .dividend    (dividend8),
    .divisor     (divisor8),
    .busy        (busy8),
    .done        (done8),
    .quotient    (quot8),
    .remainder   (rem8),
    .div_by_zero (dbz8)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitors: sample at negedge, pop expected entry whenever done is seen.
  int busy4_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy4_cnt = 0;
    end else begin
      if (busy4) busy4_cnt++;
      if (busy4 && done4) chk("n4_busy_and_done", 1, 0);
      if (done4) begin
        if (sb4.size() == 0) begin
          chk("n4_unexpected_done", 1, 0);
        end else begin
          e = sb4.pop_front();
          chk("n4_quotient", 32'(quot4), 32'(e.q));
          chk("n4_remainder", 32'(rem4), 32'(e.r));
          chk("n4_div_by_zero", 32'(dbz4), 32'(e.dbz));
          chk("n4_latency", edge_cnt - e.acc, e.edges);
          chk("n4_busy_cycles", busy4_cnt, e.busy);
        end
        busy4_cnt = 0;
      end
    end
  end

  int busy8_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy8_cnt = 0;
    end else begin
      if (busy8) busy8_cnt++;
      if (busy8 && done8) chk("n8_busy_and_done", 1, 0);
      if (done8) begin
        if (sb8.size() == 0) begin
          chk("n8_unexpected_done", 1, 0);
        end else begin
          e = sb8.pop_front();
          chk("n8_quotient", 32'(quot8), 32'(e.q));
          chk("n8_remainder", 32'(rem8), 32'(e.r));
          chk("n8_div_by_zero", 32'(dbz8), 32'(e.dbz));
          chk("n8_latency", edge_cnt - e.acc, e.edges);
          chk("n8_busy_cycles", busy8_cnt, e.busy);
        end
        busy8_cnt = 0;
      end
    end
  end

  // Call at a negedge; returns just after the accept edge.
  task automatic issue4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic [3:0] er, input logic edbz);
    exp_t e;
    dividend4 = a;
    divisor4  = b;
    start4    = 1'b1;
    e.q     = 8'(eq);
    e.r     = 8'(er);
    e.dbz   = edbz;
    e.acc   = edge_cnt + 1;
    e.edges = (b == 4'd0) ? 0 : 5;
    e.busy  = (b == 4'd0) ? 0 : 5;
    sb4.push_back(e);
    @(posedge clk);
    #1 start4 = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    dividend8 = a;
    divisor8  = b;
    start8    = 1'b1;
    e.q     = (b == 8'd0) ? 8'hff : a / b;
    e.r     = (b == 8'd0) ? a : a % b;
    e.dbz   = (b == 8'd0);
    e.acc   = edge_cnt + 1;
    e.edges = (b == 8'd0) ? 0 : 9;
    e.busy  = (b == 8'd0) ? 0 : 9;
    sb8.push_back(e);
    @(posedge clk);
    #1 start8 = 1'b0;
  endtask

  // Wait for both scoreboards to drain (bounded), then leave the DUTs idle.
  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb4.size() != 0 || sb8.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 1, 0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] va [8];
    logic [7:0] vb [8];
    va = '{8'd255, 8'd255, 8'd0, 8'd1, 8'd200, 8'd128, 8'd77, 8'd254};
    vb = '{8'd1, 8'd255, 8'd7, 8'd255, 8'd13, 8'd2, 8'd0, 8'd127};

    repeat (3) @(negedge clk);
    chk("rst_quotient", 32'(quot4), 0);
    chk("rst_remainder", 32'(rem4), 0);
    chk("rst_dbz", 32'(dbz4), 0);
    chk("rst_busy", 32'(busy4), 0);
    chk("rst_done", 32'(done4), 0);
    rst = 1'b0;
    @(negedge clk);

    issue4(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    drain();
    issue4(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    drain();
    issue4(4'd0, 4'd5, 4'd0, 4'd0, 1'b0);
    drain();
    issue4(4'd3, 4'd9, 4'd0, 4'd3, 1'b0);
    drain();
    issue4(4'd7, 4'd0, 4'd15, 4'd7, 1'b1);
    drain();
    issue4(4'd8, 4'd2, 4'd4, 4'd0, 1'b0);
    drain();

    // Back-to-back: second start lands in the DONE cycle of 13/3.
    issue4(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    repeat (6) @(negedge clk);
    issue4(4'd14, 4'd4, 4'd3, 4'd2, 1'b0);
    @(negedge clk);
    dividend4 = 4'd1;
    divisor4  = 4'd1;
    start4    = 1'b1;
    repeat (2) @(negedge clk);
    start4 = 1'b0;
    drain();

    // Reset in the third ITER cycle of 9/2, with start coincident.
    dividend4 = 4'd9;
    divisor4  = 4'd2;
    start4    = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    start4 = 1'b1;
    @(negedge clk);
    chk("midrst_quotient", 32'(quot4), 0);
    chk("midrst_remainder", 32'(rem4), 0);
    chk("midrst_dbz", 32'(dbz4), 0);
    chk("midrst_busy", 32'(busy4), 0);
    chk("midrst_done", 32'(done4), 0);
    rst    = 1'b0;
    start4 = 1'b0;
    @(negedge clk);
    chk("postrst_done", 32'(done4), 0);
    chk("postrst_busy", 32'(busy4), 0);
    issue4(4'd9, 4'd2, 4'd4, 4'd1, 1'b0);
    drain();

    // N=8: corner vectors then a random sweep.
    for (int i = 0; i < 8; i++) begin
      issue8(va[i], vb[i]);
      drain();
    end
    for (int i = 0; i < 150; i++) begin
      issue8(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
      drain();
    end

    chk("scoreboard_empty", 32'(sb4.size() + sb8.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
